// File: rtl/object_reader_pkg.sv
// object_pkg: shared geometry, object word layout and FSM/FIFO types for the object reader.
package object_pkg;
    localparam int OBJ_WIDTH      = 115;
    localparam int OBJ_COUNT      = 4;
    localparam int ADDR_WIDTH     = 8;
    localparam int PORTS          = 4;
    localparam int READ_LATENCY   = 2;
    localparam int GRP_FIFO_DEPTH = 4;
    localparam int IS_STATIC_BIT  = OBJ_WIDTH - 1;
    localparam int LANE_W         = $clog2(PORTS);

    typedef struct packed {
        logic        is_static;
        logic [17:0] id_bits;
        logic [31:0] params;
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [15:0] vel_x;
        logic [15:0] vel_y;
    } obj_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} reader_state_t;

    typedef struct packed {
        logic [PORTS-1:0]    mask;
        logic [ADDR_WIDTH:0] base;
        obj_t [PORTS-1:0]    objs;
    } group_t;

    typedef struct packed {
        logic                valid;
        logic [PORTS-1:0]    mask;
        logic [ADDR_WIDTH:0] base;
    } inflight_t;

    function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] n);
        return n > (ADDR_WIDTH+1)'(OBJ_COUNT) ? (ADDR_WIDTH+1)'(OBJ_COUNT) : n;
    endfunction
endpackage

// File: rtl/object_reader_if.sv
// object_reader_if: grouped storage read ports plus the serialized per-object stream.
interface object_reader_if;
    import object_pkg::*;
    logic                                read_valid_out;
    logic [PORTS-1:0][ADDR_WIDTH-1:0]    read_addrs_out;
    logic [PORTS-1:0][OBJ_WIDTH-1:0]     read_objects_in;
    logic                                obj_valid_out;
    logic                                obj_ready_in;
    logic [OBJ_WIDTH-1:0]                obj_out;
    logic [ADDR_WIDTH-1:0]               obj_index_out;
    logic                                obj_last_out;

    modport master (
        output read_valid_out, read_addrs_out, obj_valid_out, obj_out, obj_index_out, obj_last_out,
        input  read_objects_in, obj_ready_in
    );
    modport slave (
        input  read_valid_out, read_addrs_out, obj_valid_out, obj_out, obj_index_out, obj_last_out,
        output read_objects_in, obj_ready_in
    );
endinterface

// File: rtl/object_reader_group_fifo.sv
// group_fifo: synchronous FIFO of returned read groups (lane mask, base index, PORTS objects).
module group_fifo
    import object_pkg::*;
#(
    parameter int DEPTH = GRP_FIFO_DEPTH
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  group_t                 din,
    output group_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    group_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // storage needs no reset: the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/object_reader.sv
// object_reader: sweeps objects 0..count-1 over PORTS parallel read ports and streams them one per beat.
// Build macro OBJ_READER_STATIC_SKIP_EN drops objects whose is_static bit is set.
module object_reader
    import object_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    input  logic [ADDR_WIDTH:0] count_in,
    object_reader_if.master     bus,
    output logic                busy_out,
    output logic                done_out
);
    localparam int FIFO_CW = $clog2(GRP_FIFO_DEPTH) + 1;

    reader_state_t       state, next_state;
    logic [ADDR_WIDTH:0] count, base, obj_addr;
    logic [ADDR_WIDTH:0] lane_addr [PORTS];
    logic [PORTS-1:0]    issue_mask, done_mask, cur_mask;
    logic [LANE_W-1:0]   lane;
    inflight_t           pipe [READ_LATENCY];
    group_t              push_grp, head;
    logic [FIFO_CW-1:0]  fifo_count;
    logic                fifo_full, fifo_empty, can_issue, issue, push, pop, hs, last_lane, final_group;
    int                  inflight;

    // issue gating: never launch more groups than the FIFO can still absorb
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) inflight += int'(pipe[i].valid);
        can_issue = !fifo_full && (int'(fifo_count) + inflight < GRP_FIFO_DEPTH);
        issue = (state == ISSUE) && can_issue;
    end

    // state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else state <= next_state;
    end

    // next state: a zero-length sweep never leaves IDLE; DRAIN ends on the last beat or when nothing is left
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_in) next_state = clamp_count(count_in) == '0 ? IDLE : ISSUE;
            ISSUE:   if (issue && base + (ADDR_WIDTH+1)'(PORTS) >= count) next_state = DRAIN;
            DRAIN:   if ((hs && bus.obj_last_out) || (inflight == 0 && fifo_empty)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // issue-side outputs: strobe, per-lane address, lanes past the count are masked and driven to 0
    always_comb begin
        busy_out = state != IDLE;
        bus.read_valid_out = issue;
        for (int p = 0; p < PORTS; p++) begin
            lane_addr[p] = base + (ADDR_WIDTH+1)'(p);
            issue_mask[p] = lane_addr[p] < count;
            bus.read_addrs_out[p] = (issue && issue_mask[p]) ? lane_addr[p][ADDR_WIDTH-1:0] : '0;
        end
    end

    // sweep counters, read-latency pipe, completion pulse and per-group lane progress
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count     <= '0;
            base      <= '0;
            done_out  <= 1'b0;
            done_mask <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            if (state == IDLE && start_in) begin
                count <= clamp_count(count_in);
                base  <= '0;
            end else if (issue) begin
                base <= base + (ADDR_WIDTH+1)'(PORTS);
            end
            pipe[0] <= '{issue, issue_mask, base};
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
            done_out  <= (state != IDLE || start_in) && next_state == IDLE;
            done_mask <= pop ? '0 : hs ? done_mask | (PORTS'(1) << lane) : done_mask;
        end
    end

    // capture the returned group as its tag leaves the latency pipe
    always_comb begin
        push          = pipe[READ_LATENCY-1].valid;
        push_grp.base = pipe[READ_LATENCY-1].base;
        push_grp.objs = bus.read_objects_in;
        push_grp.mask = pipe[READ_LATENCY-1].mask;
`ifdef OBJ_READER_STATIC_SKIP_EN
        for (int p = 0; p < PORTS; p++) if (bus.read_objects_in[p][IS_STATIC_BIT]) push_grp.mask[p] = 1'b0;
`endif
    end

    group_fifo #(.DEPTH(GRP_FIFO_DEPTH)) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (push),
        .pop   (pop),
        .din   (push_grp),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // serializer: present the lowest pending lane of the head group; fully-masked groups are dropped
    always_comb begin
        cur_mask = fifo_empty ? '0 : head.mask & ~done_mask;
        lane = '0;
        for (int p = PORTS - 1; p >= 0; p--) if (cur_mask[p]) lane = LANE_W'(p);
        last_lane = (cur_mask & (cur_mask - PORTS'(1))) == '0;
        final_group = head.base + (ADDR_WIDTH+1)'(PORTS) >= count;
        obj_addr = head.base + (ADDR_WIDTH+1)'(lane);
        bus.obj_valid_out = |cur_mask;
        bus.obj_out = bus.obj_valid_out ? head.objs[lane] : '0;
        bus.obj_index_out = bus.obj_valid_out ? obj_addr[ADDR_WIDTH-1:0] : '0;
        bus.obj_last_out = bus.obj_valid_out && last_lane && final_group;
        hs = bus.obj_valid_out && bus.obj_ready_in;
        pop = !fifo_empty && (cur_mask == '0 || (hs && last_lane));
    end
endmodule

// File: tb/tb_object_reader.sv
// tb_object_reader: directed self-checking bench for object_reader with a 2-cycle BRAM model.
module tb_object_reader;
    import object_pkg::*;

    logic clk = 1'b0;
    logic rst_n, start, busy, done;
    logic [ADDR_WIDTH:0] count;
    object_reader_if bus();

    object_reader dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .start_in (start),
        .count_in (count),
        .bus      (bus.master),
        .busy_out (busy),
        .done_out (done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, start_cyc = 0;
    logic busy1;
    logic [3:0] static_mask = 4'b0000;
    int idx_q[$], beat_q[$], issue_q[$], done_q[$];
    logic last_q[$];
    logic [OBJ_WIDTH-1:0] obj_q[$];
    logic [31:0] addr_q[$];
    logic [PORTS-1:0][OBJ_WIDTH-1:0] s1;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [OBJ_WIDTH+ADDR_WIDTH:0] prev_beat;

    function automatic logic [OBJ_WIDTH-1:0] obj_val(input int a);
        logic st;
        st = (a < 4) ? static_mask[a] : 1'b0;
        return {st, 18'(a + 1), 32'(32'hBEEF0000 + a), 16'(a * 3), 16'(a * 5), 16'(a * 7), 16'(a * 11)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int p = 0; p < PORTS; p++) s1[p] <= obj_val(int'(bus.read_addrs_out[p]));
        bus.read_objects_in <= s1;
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold valid", bus.obj_valid_out, 1'b1);
                check("hold beat", {bus.obj_out, bus.obj_index_out, bus.obj_last_out}, prev_beat);
            end
            if (bus.read_valid_out) begin
                issue_q.push_back(cyc);
                addr_q.push_back(bus.read_addrs_out);
            end
            if (bus.obj_valid_out && bus.obj_ready_in) begin
                idx_q.push_back(int'(bus.obj_index_out));
                last_q.push_back(bus.obj_last_out);
                obj_q.push_back(bus.obj_out);
                beat_q.push_back(cyc);
            end
            if (done) done_q.push_back(cyc);
            prev_valid = bus.obj_valid_out;
            prev_ready = bus.obj_ready_in;
            prev_beat  = {bus.obj_out, bus.obj_index_out, bus.obj_last_out};
        end
    end

    task automatic run(input string tag, input int n, input bit stall, input bit restart);
        idx_q.delete(); beat_q.delete(); issue_q.delete(); done_q.delete();
        last_q.delete(); obj_q.delete(); addr_q.delete();
        @(negedge clk);
        start = 1'b1;
        count = (ADDR_WIDTH+1)'(n);
        bus.obj_ready_in = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        #2 busy1 = busy;
        for (int k = 1; k < 100 && done_q.size() == 0; k++) begin
            @(negedge clk);
            bus.obj_ready_in = stall ? (k % 3 == 0) : 1'b1;
            start = restart && k == 2;
            if (restart && k == 2) count = 1;
        end
        start = 1'b0;
        bus.obj_ready_in = 1'b1;
        check({tag, " finished"}, done_q.size() > 0, 1'b1);
        repeat (3) @(negedge clk);
        check({tag, " idle busy"}, busy, 1'b0);
    endtask

    task automatic check_stream(input string tag, input logic [3:0] set);
        int exp[$];
        for (int i = 0; i < 4; i++) if (set[i]) exp.push_back(i);
        check({tag, " beats"}, idx_q.size(), exp.size());
        for (int j = 0; j < exp.size() && j < idx_q.size(); j++) begin
            check({tag, " index"}, idx_q[j], exp[j]);
            check({tag, " obj"}, obj_q[j], obj_val(exp[j]));
            check({tag, " last"}, last_q[j], j == exp.size() - 1);
        end
        check({tag, " done pulses"}, done_q.size(), 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; count = '0; bus.obj_ready_in = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset read_valid", bus.read_valid_out, 1'b0);
        check("reset addrs", bus.read_addrs_out, 32'h0);
        check("reset obj_valid", bus.obj_valid_out, 1'b0);
        rst_n = 1'b1;

        run("full4", 4, 1'b0, 1'b0);
        check("full4 busy", busy1, 1'b1);
        check("full4 issues", issue_q.size(), 1);
        check("full4 addrs", addr_q[0], 32'h03020100);
        check("full4 issue cyc", issue_q[0] - start_cyc, 1);
        check("full4 first beat", beat_q[0] - start_cyc, 4);
        check("full4 last beat", beat_q[3] - start_cyc, 7);
        check("full4 done cyc", done_q[0] - start_cyc, 8);
        check_stream("full4", 4'b1111);

        run("cnt3", 3, 1'b0, 1'b0);
        check("cnt3 addrs", addr_q[0], 32'h00020100);
        check_stream("cnt3", 4'b0111);

        run("cnt0", 0, 1'b0, 1'b0);
        check("cnt0 busy", busy1, 1'b0);
        check("cnt0 issues", issue_q.size(), 0);
        check("cnt0 done cyc", done_q[0] - start_cyc, 1);
        check_stream("cnt0", 4'b0000);

        run("clamp", 9, 1'b0, 1'b0);
        check("clamp addrs", addr_q[0], 32'h03020100);
        check_stream("clamp", 4'b1111);

        run("stall", 4, 1'b1, 1'b1);
        check("stall issues", issue_q.size(), 1);
        check_stream("stall", 4'b1111);

        @(negedge clk);
        start = 1'b1; count = 4; bus.obj_ready_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !bus.obj_valid_out; k++) @(negedge clk);
        check("abort pending", bus.obj_valid_out, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort obj_valid", bus.obj_valid_out, 1'b0);
        check("abort beat", {bus.obj_out, bus.obj_index_out, bus.obj_last_out}, '0);
        check("abort read_valid", bus.read_valid_out, 1'b0);
        check("abort addrs", bus.read_addrs_out, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run("post", 2, 1'b0, 1'b0);
        check("post first beat", beat_q[0] - start_cyc, 4);
        check("post done cyc", done_q[0] - start_cyc, 6);
        check_stream("post", 4'b0011);

        static_mask = 4'b1010;
        run("static", 4, 1'b0, 1'b0);
`ifdef OBJ_READER_STATIC_SKIP_EN
        check_stream("static", 4'b0101);
`else
        check_stream("static", 4'b1111);
`endif

        static_mask = 4'b1111;
        run("allstatic", 4, 1'b0, 1'b0);
`ifdef OBJ_READER_STATIC_SKIP_EN
        check_stream("allstatic", 4'b0000);
`else
        check_stream("allstatic", 4'b1111);
`endif
        static_mask = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
